// File: rtl/gearbox_32_33.sv
// gearbox_32_33: receive-side 32->33 bit width converter.
// Collects the 32-bit lane stream into a 64-bit shift buffer (oldest bit at
// [0]) and emits registered 33-bit words as soon as enough bits are held.
// A one-bit slip input lets downstream word-lock logic walk the 33-bit
// boundary; a slip that arrives with nothing buffered is remembered and
// applied to the first bit that arrives afterwards.
module gearbox_32_33 (
  input  logic        clk,
  input  logic        arst,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [32:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  input  logic        slip
);

  logic [63:0] storage;
  logic [6:0]  holding;
  logic        slip_pending;

  logic        pop;
  logic [6:0]  hold_pop;
  logic [63:0] stor_pop;
  logic        accept;
  logic        do_slip;
  logic        slip_now;
  logic [6:0]  hold_slip;
  logic [63:0] stor_slip;
  logic        pend_nxt;
  logic [6:0]  hold_nxt;
  logic [63:0] stor_nxt;

  // Next-state of the buffer: pop a word, then slip, then append new lane data.
  always_comb begin
    pop       = (holding >= 7'd33) && (!dout_valid || dout_ready);
    hold_pop  = pop ? (holding - 7'd33) : holding;
    stor_pop  = pop ? {33'b0, storage[63:33]} : storage;

    // Readiness ignores a possible slip this cycle; that only ever makes it
    // stricter, so the buffer can never overflow.
    din_ready = (hold_pop <= 7'd32);
    accept    = din_valid && din_ready;

    // A slip with an empty buffer is parked until a bit is available; a
    // second slip while one is parked merges with it.
    do_slip   = slip || slip_pending;
    slip_now  = do_slip && (hold_pop != 7'd0);
    hold_slip = slip_now ? (hold_pop - 7'd1) : hold_pop;
    stor_slip = slip_now ? {1'b0, stor_pop[63:1]} : stor_pop;
    pend_nxt  = do_slip && (hold_pop == 7'd0);

    // New lane bits land just above the bits still held (hold_slip <= 32
    // whenever accept is set, so nothing is shifted out of the top).
    stor_nxt  = accept ? (stor_slip | ({32'b0, din} << hold_slip)) : stor_slip;
    hold_nxt  = accept ? (hold_slip + 7'd32) : hold_slip;
  end

  // Register buffer state and the output word; dout holds until consumed.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      storage      <= '0;
      holding      <= '0;
      slip_pending <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
    end else begin
      storage      <= stor_nxt;
      holding      <= hold_nxt;
      slip_pending <= pend_nxt;
      if (pop) begin
        dout       <= storage[32:0];
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gearbox_32_33.sv
// tb_gearbox_32_33: randomized scoreboard bench for the 32->33 gearbox.
// The reference model treats the lane as a plain bit stream: accepted din
// bits are appended LSB first, a slip deletes the oldest not-yet-framed bit
// (or the next bit to arrive when none is buffered), and every 33 bits form
// one expected word. A monitor pops and compares on each dout handshake.
module tb_gearbox_32_33;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [32:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        slip = 1'b0;

  int checks = 0;
  int failures = 0;
  int word_cnt = 0;

  bit          mbits[$];
  logic [32:0] exp_q[$];
  bit          mpend = 1'b0;
  bit          txb[$];
  logic [32:0] txw_q[$];
  bit          lock_chk = 1'b0;
  int          tx_words = 0;
  bit          hold_v = 1'b0;
  logic [32:0] hold_d = '0;

  gearbox_32_33 dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .slip       (slip)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_push(input logic [31:0] d);
    logic [32:0] w;
    for (int i = 0; i < 32; i++) begin
      if (mpend) mpend = 1'b0;
      else mbits.push_back(d[i]);
    end
    while (mbits.size() >= 33) begin
      for (int j = 0; j < 33; j++) w[j] = mbits.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic model_slip();
    if (mbits.size() > 0) void'(mbits.pop_front());
    else mpend = 1'b1;
  endtask

  // Transmit-side 33->32 gearbox model: random words serialized LSB first.
  task automatic next_din(output logic [31:0] d);
    logic [32:0] w;
    while (txb.size() < 32) begin
      w[31:0] = $urandom;
      w[32]   = 1'($urandom_range(0, 1));
      txw_q.push_back(w);
      tx_words++;
      for (int j = 0; j < 33; j++) txb.push_back(w[j]);
    end
    for (int i = 0; i < 32; i++) d[i] = txb.pop_front();
  endtask

  // One clock cycle: drive just after the edge, decide acceptance mid-cycle.
  task automatic step(input logic v, input logic [31:0] d, input logic r,
                      input logic s, output logic acc);
    @(posedge clk);
    #1;
    din_valid  = v;
    din        = d;
    dout_ready = r;
    slip       = s;
    @(negedge clk);
    acc = v && din_ready;
    if (s) model_slip();
    if (acc) model_push(d);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    slip      = 1'b0;
    arst      = 1'b1;
    #1;
    chk("rst_dout_valid", 64'(dout_valid), 64'(0));
    chk("rst_din_ready", 64'(din_ready), 64'(1));
    chk("rst_dout", 64'(dout), 64'(0));
    mbits.delete();
    exp_q.delete();
    mpend  = 1'b0;
    hold_v = 1'b0;
    #1;
    arst = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    repeat (5) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    chk("drain_all_words_seen", 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard monitor: stability under backpressure and word-by-word compare.
  always @(negedge clk) begin
    if (!arst) begin
      if (hold_v) begin
        chk("held_dout_valid", 64'(dout_valid), 64'(1));
        chk("held_dout_stable", 64'(dout), 64'(hold_d));
      end
      if (dout_valid && dout_ready) begin
        word_cnt++;
        if (exp_q.size() == 0) chk("no_word_expected_valid", 64'(dout_valid), 64'(0));
        else chk("dout_word", 64'(dout), 64'(exp_q.pop_front()));
        if (lock_chk && txw_q.size() > 0) chk("tx_word", 64'(dout), 64'(txw_q.pop_front()));
      end
      hold_v = dout_valid && !dout_ready;
      hold_d = dout;
    end
  end

  initial begin
    logic        acc;
    logic [31:0] d;
    int          lows;
    int          ready_lows;
    int          cyc;
    int          start;
    bit          have;

    repeat (3) @(posedge clk);
    do_reset();

    // Slip right after reset (parked, merged), then a 5-bit offset stream.
    txb.delete();
    txw_q.delete();
    for (int i = 0; i < 5; i++) txb.push_back(1'($urandom_range(0, 1)));
    lock_chk = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    step(1'b0, 32'h0, 1'b1, 1'b1, acc);
    next_din(d);
    step(1'b1, d, 1'b1, 1'b0, acc);
    chk("slip_first_accept", 64'(acc), 64'(1));
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b1, acc);
      repeat (2) step(1'b0, 32'h0, 1'b1, 1'b0, acc);
    end
    for (int i = 0; i < 40; i++) begin
      next_din(d);
      step(1'b1, d, 1'b1, 1'b0, acc);
      chk("slip_stream_accept", 64'(acc), 64'(1));
    end
    drain();
    lock_chk = 1'b0;

    // Bit order: earliest bit of the first din is dout bit 0.
    do_reset();
    step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
    step(1'b1, 32'h0000_0001, 1'b1, 1'b0, acc);
    repeat (3) step(1'b1, 32'h0, 1'b1, 1'b0, acc);
    drain();

    // Full rate all-ones: din_ready always high, one idle output per 33 cycles.
    do_reset();
    lows = 0;
    for (int i = 0; i < 99; i++) begin
      step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, acc);
      chk("full_rate_din_ready", 64'(acc), 64'(1));
      if (i >= 40 && i <= 72 && !dout_valid) lows++;
    end
    chk("full_rate_idle_per_33", 64'(lows), 64'(1));
    drain();

    // Backpressure: consumer stalls 10 cycles under continuous input.
    ready_lows = 0;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      step(1'b1, d, 1'b0, 1'b0, acc);
      if (!acc) ready_lows++;
      if (i == 9) chk("bp_din_ready_low", 64'(acc), 64'(0));
    end
    chk("bp_din_ready_dropped", 64'(ready_lows > 0), 64'(1));
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      step(1'b1, d, 1'b1, 1'b0, acc);
    end
    drain();

    // Reset mid-stream with a word held in dout.
    for (int i = 0; i < 5; i++) begin
      d = $urandom;
      step(1'b1, d, 1'b0, 1'b0, acc);
    end
    do_reset();

    // Loopback: 10001 transmitted words, random gaps and stalls.
    txb.delete();
    txw_q.delete();
    tx_words = 0;
    lock_chk = 1'b1;
    start = word_cnt;
    have = 1'b0;
    cyc = 0;
    d = '0;
    while ((have || tx_words < 10001 || txb.size() >= 32) && cyc < 60000) begin
      if (!have) begin
        next_din(d);
        have = 1'b1;
      end
      step(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 3) != 0), 1'b0, acc);
      if (acc) have = 1'b0;
      cyc++;
    end
    chk("loopback_cycles_bounded", 64'(cyc < 60000), 64'(1));
    drain();
    chk("loopback_word_count", 64'(word_cnt - start), 64'(10000));
    lock_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
